key_search_ctrl: RTL and testbench

Brute-force key search controller wrapped around the `arcfour` core. It drives the 24-bit key and the one-cycle start pulse into `arcfour`, then waits for `arcfour_finished`. It then reads the 32-byte decrypted-message RAM that `arcfour` fills and checks every byte for lowercase ASCII or space. On the first invalid byte it advances to the next key; it stops when a key yields a fully valid message or the key space is exhausted.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/trap_edge.sv | 22 ++
 rtl/key_search_ctrl.sv | 115 +++++++++++
 tb/tb_key_search_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key search slice.
// Holds the search FSM encoding and the printable-byte bounds.
package rc4_pkg;

    typedef enum logic [2:0] {
        KS_IDLE     = 3'd0,
        KS_LAUNCH   = 3'd1,
        KS_WAIT_ARC = 3'd2,
        KS_RD_ADDR  = 3'd3,
        KS_RD_WAIT  = 3'd4,
        KS_CHECK    = 3'd5,
        KS_NEXT_KEY = 3'd6,
        KS_DONE     = 3'd7
    } ks_state_t;

    localparam logic [7:0] ASCII_LO = 8'h61;
    localparam logic [7:0] ASCII_HI = 8'h7A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam int unsigned MSG_LEN_DEFAULT = 32;

endpackage

// File: rtl/trap_edge.sv
// Registered rising-edge detector: rise pulses for one cycle after sig
// is first sampled high following a low sample.
module trap_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sig_prev <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sig_prev <= sig;
            rise     <= sig & ~sig_prev;
        end
    end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search around the arcfour core: launch a key, wait for
// completion, scan the decrypted RAM for lowercase/space, advance on failure.
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter logic [21:0] KEY_MAX = 22'h3FFFFF,
    parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic [23:0]       key,
    output logic              arc_start,
    input  logic              arc_finished,
    output logic [ADDR_W-1:0] msg_addr,
    input  logic [7:0]        msg_q,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic [23:0]       found_key
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    ks_state_t   state;
    logic [21:0] key_cnt;
    logic        arc_rise;
    logic        byte_ok;

    // A level left high by the previous key never registers as a new edge.
    trap_edge u_finished_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (arc_finished),
        .rise  (arc_rise)
    );

    assign key = {2'b00, key_cnt};

    always_comb begin
        byte_ok = ((msg_q >= ASCII_LO) && (msg_q <= ASCII_HI)) || (msg_q == ASCII_SP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= KS_IDLE;
            key_cnt   <= '0;
            arc_start <= 1'b0;
            msg_addr  <= '0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            found_key <= '0;
        end else begin
            arc_start <= 1'b0;
            case (state)
                KS_IDLE, KS_DONE: begin
                    if (go) begin
                        key_cnt   <= '0;
                        msg_addr  <= '0;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        busy      <= 1'b1;
                        arc_start <= 1'b1;
                        state     <= KS_LAUNCH;
                    end
                end
                KS_LAUNCH: begin
                    state <= KS_WAIT_ARC;
                end
                KS_WAIT_ARC: begin
                    if (arc_rise) begin
                        msg_addr <= '0;
                        state    <= KS_RD_ADDR;
                    end
                end
                KS_RD_ADDR: begin
                    state <= KS_RD_WAIT;
                end
                KS_RD_WAIT: begin
                    state <= KS_CHECK;
                end
                KS_CHECK: begin
                    if (!byte_ok) begin
                        state <= KS_NEXT_KEY;
                    end else if (msg_addr == LAST_ADDR) begin
                        found     <= 1'b1;
                        found_key <= key;
                        busy      <= 1'b0;
                        state     <= KS_DONE;
                    end else begin
                        msg_addr <= msg_addr + ADDR_W'(1);
                        state    <= KS_RD_ADDR;
                    end
                end
                KS_NEXT_KEY: begin
                    if (key_cnt == KEY_MAX) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= KS_DONE;
                    end else begin
                        key_cnt   <= key_cnt + 22'd1;
                        arc_start <= 1'b1;
                        state     <= KS_LAUNCH;
                    end
                end
                default: begin
                    state <= KS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench for key_search_ctrl with an arcfour latency model and a
// per-key message RAM; expected search results are queued at each go.
module tb_key_search_ctrl;

    localparam int          MSG_LEN = 32;
    localparam int          NKEYS   = 4;
    localparam logic [21:0] KMAX    = 22'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        arc_start;
    logic        arc_finished = 1'b0;
    logic [4:0]  msg_addr;
    logic [7:0]  msg_q;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [23:0] key;
    logic [23:0] found_key;

    key_search_ctrl #(.KEY_MAX(KMAX), .MSG_LEN(MSG_LEN), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .key          (key),
        .arc_start    (arc_start),
        .arc_finished (arc_finished),
        .msg_addr     (msg_addr),
        .msg_q        (msg_q),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .found_key    (found_key)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Message RAM: one 32-byte image per key, registered read.
    logic [7:0] mem [NKEYS][MSG_LEN];
    always @(posedge clk) msg_q <= mem[key[1:0]][msg_addr];

    // arcfour model: finished rises 10 cycles after start; hold_mode keeps the
    // old level high through launch and drops it a few cycles later.
    bit hold_mode = 1'b0;
    bit arc_run   = 1'b0;
    int arc_cnt   = 0;
    always @(posedge clk) begin
        if (arc_start) begin
            arc_run <= 1'b1;
            arc_cnt <= 0;
            if (!hold_mode) arc_finished <= 1'b0;
        end else if (arc_run) begin
            arc_cnt <= arc_cnt + 1;
            if (arc_cnt == 3) arc_finished <= 1'b0;
            if (arc_cnt == 9) begin
                arc_finished <= 1'b1;
                arc_run      <= 1'b0;
            end
        end
    end

    // Monitor: capture timing and results away from the active edge.
    int          launch_total = 0, addr_nz = 0, key_bad = 0, both_bad = 0, done_cnt = 0;
    int          fin_cyc = 0, last_start_cyc = 0, found_gap = 0, reject_gap = 0, start_to_done = 0;
    bit          fin_valid = 1'b0, arc_prev = 1'b0, done_prev = 1'b0;
    logic [23:0] start_key = '0;
    logic        d_found, d_exh;
    logic [23:0] d_key, d_fkey;
    int          d_launch_total = 0;

    always @(negedge clk) begin
        if (arc_start === 1'b1) begin
            launch_total++;
            last_start_cyc = cyc;
            start_key      = key;
            if (fin_valid) reject_gap = cyc - fin_cyc;
            fin_valid = 1'b0;
        end
        if (arc_finished && !arc_prev) begin
            fin_cyc   = cyc;
            fin_valid = 1'b1;
            if (busy === 1'b1 && key !== start_key) key_bad++;
        end
        arc_prev = arc_finished;
        if (found === 1'b1 && exhausted === 1'b1) both_bad++;
        if (msg_addr != 0) addr_nz++;
        if (busy === 1'b0 && (found === 1'b1 || exhausted === 1'b1) && !done_prev) begin
            found_gap      = cyc - fin_cyc;
            start_to_done  = cyc - last_start_cyc;
            d_found        = found;
            d_exh          = exhausted;
            d_key          = key;
            d_fkey         = found_key;
            d_launch_total = launch_total;
            done_cnt++;
        end
        done_prev = (busy === 1'b0) && (found === 1'b1 || exhausted === 1'b1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic        found;
        logic        exh;
        logic [23:0] fkey;
        logic [23:0] ekey;
        int          launches;
        int          base;
    } res_t;

    res_t exp_q[$];

    function automatic bit legal(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic res_t predict();
        res_t r;
        r.found    = 1'b0;
        r.exh      = 1'b1;
        r.fkey     = '0;
        r.ekey     = 24'(KMAX);
        r.launches = NKEYS;
        r.base     = launch_total;
        for (int k = 0; k < NKEYS; k++) begin
            bit ok = 1'b1;
            for (int a = 0; a < MSG_LEN; a++)
                if (!legal(mem[k][a])) ok = 1'b0;
            if (ok && !r.found) begin
                r.found    = 1'b1;
                r.exh      = 1'b0;
                r.fkey     = 24'(k);
                r.ekey     = 24'(k);
                r.launches = k + 1;
            end
        end
        return r;
    endfunction

    task automatic fill_all(input logic [7:0] b);
        for (int k = 0; k < NKEYS; k++)
            for (int a = 0; a < MSG_LEN; a++)
                mem[k][a] = b;
    endtask

    task automatic start_search(input bit push);
        if (push) exp_q.push_back(predict());
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check_val("go_busy", busy, 1);
        check_val("go_arc_start", arc_start, 1);
        check_val("go_key", key, 0);
        check_val("go_found_clr", found, 0);
        check_val("go_exh_clr", exhausted, 0);
    endtask

    task automatic wait_score(input string tag);
        int   start_cnt = done_cnt;
        int   i = 0;
        res_t e;
        while (done_cnt == start_cnt && i < 3000) begin
            @(posedge clk);
            i++;
        end
        check_val({tag, "_done_in_time"}, done_cnt != start_cnt, 1);
        check_val({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
        if (done_cnt != start_cnt && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_found"}, d_found, e.found);
            check_val({tag, "_exhausted"}, d_exh, e.exh);
            check_val({tag, "_key"}, d_key, e.ekey);
            check_val({tag, "_launches"}, d_launch_total - e.base, e.launches);
            if (e.found) check_val({tag, "_found_key"}, d_fkey, e.fkey);
        end
    endtask

    logic [7:0] bvals [5] = '{8'h60, 8'h7B, 8'h61, 8'h7A, 8'h20};
    bit         brej  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int base, a0, l0, i;
        fill_all(8'h61);
        repeat (3) @(negedge clk);
        check_val("rst_key", key, 0);
        check_val("rst_arc_start", arc_start, 0);
        check_val("rst_msg_addr", msg_addr, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_found", found, 0);
        check_val("rst_exhausted", exhausted, 0);
        check_val("rst_found_key", found_key, 0);
        reset = 1'b1;

        // Valid message on the first key.
        start_search(1'b1);
        wait_score("k0");
        check_val("k0_found_gap", found_gap, 98);
        check_val("k0_start_to_found", start_to_done, 109);

        // Restart from DONE with finished still high from the last key.
        hold_mode = 1'b1;
        fill_all(8'h20);
        start_search(1'b1);
        wait_score("hold");
        check_val("hold_start_to_found", start_to_done, 109);
        hold_mode = 1'b0;

        // Keys 0-2 rejected on byte 0, key 3 accepted.
        fill_all(8'h20);
        for (int k = 0; k < 3; k++) mem[k][0] = 8'h7B;
        start_search(1'b1);
        wait_score("rej3");
        check_val("rej3_gap_byte0", reject_gap, 6);

        // go held across RD_ADDR/RD_WAIT/CHECK must be ignored.
        fill_all(8'h7A);
        start_search(1'b1);
        i = 0;
        while (msg_addr != 5 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check_val("gochk_addr5_seen", msg_addr, 5);
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        wait_score("gochk");
        check_val("gochk_found_gap", found_gap, 98);

        // Boundary bytes at the last address.
        for (int v = 0; v < 5; v++) begin
            fill_all(8'h61);
            for (int k = 0; k < NKEYS; k++) mem[k][31] = bvals[v];
            start_search(1'b1);
            wait_score($sformatf("byte_%02h", bvals[v]));
            if (brej[v]) check_val($sformatf("byte_%02h_rej_gap", bvals[v]), reject_gap, 99);
            else         check_val($sformatf("byte_%02h_found_gap", bvals[v]), found_gap, 98);
        end

        // Exhaustion: key parks at KEY_MAX, no wrap.
        fill_all(8'h00);
        start_search(1'b1);
        wait_score("exh");
        repeat (20) @(negedge clk);
        check_val("exh_key_held", key, 24'h000003);
        check_val("exh_sticky", exhausted, 1);
        check_val("exh_found_low", found, 0);

        // Reset while waiting on key 1; the stale finished edge must not read.
        fill_all(8'h20);
        mem[0][0] = 8'h00;
        base = launch_total;
        start_search(1'b0);
        i = 0;
        while (launch_total != base + 2 && i < 500) begin
            @(posedge clk);
            i++;
        end
        check_val("mid_second_launch", launch_total - base, 2);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("mid_busy", busy, 0);
        check_val("mid_key", key, 0);
        check_val("mid_arc_start", arc_start, 0);
        check_val("mid_found", found, 0);
        a0 = addr_nz;
        l0 = launch_total;
        repeat (150) @(negedge clk);
        check_val("mid_no_read", addr_nz - a0, 0);
        check_val("mid_no_launch", launch_total - l0, 0);
        check_val("mid_idle", busy, 0);

        // Normal search after the mid-search reset.
        fill_all(8'h61);
        start_search(1'b1);
        wait_score("recover");

        check_val("key_stable_while_running", key_bad, 0);
        check_val("found_exh_exclusive", both_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
